// File: rtl/dual_grant_arbiter_pkg.sv
// Shared constants and slot-state encoding for the dual-grant round-robin arbiter.
package dual_grant_arbiter_pkg;

    localparam int N_DEF        = 12;
    localparam int MAX_HOLD_DEF = 16;
    localparam int IDX_W        = 4;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

endpackage

// File: rtl/dual_grant_arbiter_rr_dual_select.sv
// Combinational round-robin picker: returns the first two eligible indices scanning from ptr.
module rr_dual_select
    import dual_grant_arbiter_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:1]       eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] first,
    output logic [IDX_W-1:0] second
);

    logic [IDX_W-1:0] ptr_s;

    // An out-of-range pointer falls back to index 1 so the scan never touches bit 0.
    assign ptr_s = ((ptr == '0) || (ptr > IDX_W'(N))) ? IDX_W'(1) : ptr;

    // Wrap-around scan; first hit fills first, next hit fills second.
    always_comb begin : scan
        logic [IDX_W:0]   sum_s;
        logic [IDX_W-1:0] idx_s;
        logic             found1_s;
        logic             found2_s;
        first    = '0;
        second   = '0;
        found1_s = 1'b0;
        found2_s = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_s} + k[IDX_W:0];
            sum_s = (sum_s > (IDX_W+1)'(N)) ? (sum_s - (IDX_W+1)'(N)) : sum_s;
            idx_s = sum_s[IDX_W-1:0];
            second   = (eligible[idx_s] && found1_s && !found2_s) ? idx_s : second;
            found2_s = found2_s | (eligible[idx_s] & found1_s);
            first    = (eligible[idx_s] && !found1_s) ? idx_s : first;
            found1_s = found1_s | eligible[idx_s];
        end
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Two-slot round-robin arbiter with per-slot hold limit, revoke masking and timeout pulse.
module dual_grant_arbiter
    import dual_grant_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N:1]       req,
    output logic [N:1]       gnt,
    output logic [IDX_W-1:0] id_a,
    output logic [IDX_W-1:0] id_b,
    output logic             timeout
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    slot_state_t      state_a_r, state_b_r;
    logic [IDX_W-1:0] id_a_r, id_b_r;
    logic [CNT_W-1:0] cnt_a_r, cnt_b_r;
    logic [N:1]       mask_r, gnt_r;
    logic [IDX_W-1:0] ptr_r;
    logic             timeout_r;

    logic [N:1]       held_s, eligible_s;
    logic             hold_a_s, hold_b_s, rel_a_s, rel_b_s, rev_a_s, rev_b_s;
    logic [IDX_W-1:0] first_s, second_s, fill_a_s, fill_b_s, last_s, ptr_nx_s;
    logic [IDX_W-1:0] id_a_nx_s, id_b_nx_s;

    function automatic logic [N:1] onehot(input logic [IDX_W-1:0] idx);
        return (idx == '0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << (idx - IDX_W'(1)));
    endfunction

    assign held_s     = ((state_a_r == BUSY) ? onehot(id_a_r) : '0)
                      | ((state_b_r == BUSY) ? onehot(id_b_r) : '0);
    assign eligible_s = req & ~held_s & ~mask_r;

    assign hold_a_s = |(req & onehot(id_a_r));
    assign hold_b_s = |(req & onehot(id_b_r));
    assign rel_a_s  = (state_a_r == BUSY) && !hold_a_s;
    assign rel_b_s  = (state_b_r == BUSY) && !hold_b_s;
    assign rev_a_s  = (state_a_r == BUSY) && hold_a_s && (cnt_a_r == CNT_W'(MAX_HOLD-1));
    assign rev_b_s  = (state_b_r == BUSY) && hold_b_s && (cnt_b_r == CNT_W'(MAX_HOLD-1));

    rr_dual_select #(.N(N)) u_select (
        .eligible (eligible_s),
        .ptr      (ptr_r),
        .first    (first_s),
        .second   (second_s)
    );

    // A slot released or revoked this edge is still BUSY, so it cannot be refilled until next cycle.
    assign fill_a_s  = (state_a_r == FREE) ? first_s : '0;
    assign fill_b_s  = (state_b_r == FREE) ? ((state_a_r == FREE) ? second_s : first_s) : '0;
    assign last_s    = (fill_b_s != '0) ? fill_b_s : fill_a_s;
    assign ptr_nx_s  = (last_s == '0) ? ptr_r :
                       (last_s == IDX_W'(N)) ? IDX_W'(1) : (last_s + IDX_W'(1));
    assign id_a_nx_s = (state_a_r == BUSY) ? ((rel_a_s || rev_a_s) ? '0 : id_a_r) : fill_a_s;
    assign id_b_nx_s = (state_b_r == BUSY) ? ((rel_b_s || rev_b_s) ? '0 : id_b_r) : fill_b_s;

    // Slot FSMs, hold counters, revoke mask, pointer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_a_r <= FREE;
            state_b_r <= FREE;
            id_a_r    <= '0;
            id_b_r    <= '0;
            cnt_a_r   <= '0;
            cnt_b_r   <= '0;
            mask_r    <= '0;
            gnt_r     <= '0;
            ptr_r     <= IDX_W'(1);
            timeout_r <= 1'b0;
        end else begin
            case (state_a_r)
                FREE: begin
                    state_a_r <= (fill_a_s != '0) ? BUSY : FREE;
                    cnt_a_r   <= '0;
                end
                BUSY: begin
                    state_a_r <= (rel_a_s || rev_a_s) ? FREE : BUSY;
                    cnt_a_r   <= (rel_a_s || rev_a_s) ? '0 : (cnt_a_r + CNT_W'(1));
                end
                default: begin
                    state_a_r <= FREE;
                    cnt_a_r   <= '0;
                end
            endcase
            case (state_b_r)
                FREE: begin
                    state_b_r <= (fill_b_s != '0) ? BUSY : FREE;
                    cnt_b_r   <= '0;
                end
                BUSY: begin
                    state_b_r <= (rel_b_s || rev_b_s) ? FREE : BUSY;
                    cnt_b_r   <= (rel_b_s || rev_b_s) ? '0 : (cnt_b_r + CNT_W'(1));
                end
                default: begin
                    state_b_r <= FREE;
                    cnt_b_r   <= '0;
                end
            endcase
            id_a_r    <= id_a_nx_s;
            id_b_r    <= id_b_nx_s;
            gnt_r     <= onehot(id_a_nx_s) | onehot(id_b_nx_s);
            ptr_r     <= ptr_nx_s;
            // A revoked requester stays masked until it is seen low at an edge.
            mask_r    <= (mask_r & req)
                       | (rev_a_s ? onehot(id_a_r) : '0)
                       | (rev_b_s ? onehot(id_b_r) : '0);
            timeout_r <= rev_a_s | rev_b_s;
        end
    end

    assign gnt     = gnt_r;
    assign id_a    = id_a_r;
    assign id_b    = id_b_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Directed self-checking bench for dual_grant_arbiter with hand-computed expectations.
module tb_dual_grant_arbiter;

    logic        clk;
    logic        reset;
    logic [12:1] req;
    logic [12:1] gnt;
    logic [3:0]  id_a;
    logic [3:0]  id_b;
    logic        timeout;

    int checks_r   = 0;
    int failures_r = 0;

    dual_grant_arbiter #(.N(12), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .id_a    (id_a),
        .id_b    (id_b),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            failures_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 12'h000;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                                input logic [11:0] eg, input logic et);
        check_eq({tag, "_id_a"}, 32'(id_a), 32'(ea));
        check_eq({tag, "_id_b"}, 32'(id_b), 32'(eb));
        check_eq({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check_eq({tag, "_timeout"}, 32'(timeout), 32'(et));
    endtask

    initial begin
        reset = 1'b1;
        req   = 12'h000;
        tick();
        expect_state("reset", 4'd0, 4'd0, 12'h000, 1'b0);
        reset = 1'b0;

        // Single requester: grant one edge later, freed one edge after release.
        req = 12'h001;
        tick();
        expect_state("single_grant", 4'd1, 4'd0, 12'h001, 1'b0);
        req = 12'h000;
        tick();
        expect_state("single_release", 4'd0, 4'd0, 12'h000, 1'b0);

        // Requests 3, 7, 12 from ptr=1; then 3 releases and 12 takes slot A.
        do_reset();
        req = 12'h844;
        tick();
        expect_state("pair_grant", 4'd3, 4'd7, 12'h044, 1'b0);
        req = 12'h840;
        tick();
        expect_state("pair_release", 4'd0, 4'd7, 12'h040, 1'b0);
        tick();
        expect_state("pair_refill", 4'd12, 4'd7, 12'h840, 1'b0);

        // Requester 5 held: 16 BUSY cycles then revoke, masked until it drops.
        do_reset();
        req = 12'h010;
        tick();
        expect_state("hold_fill", 4'd5, 4'd0, 12'h010, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        expect_state("hold_last", 4'd5, 4'd0, 12'h010, 1'b0);
        tick();
        expect_state("hold_revoke", 4'd0, 4'd0, 12'h000, 1'b1);
        tick();
        expect_state("hold_pulse_end", 4'd0, 4'd0, 12'h000, 1'b0);
        tick();
        tick();
        expect_state("hold_masked", 4'd0, 4'd0, 12'h000, 1'b0);
        req = 12'h000;
        tick();
        req = 12'h010;
        tick();
        expect_state("hold_regrant", 4'd5, 4'd0, 12'h010, 1'b0);

        // Both slots expire on the same edge: one timeout pulse.
        do_reset();
        req = 12'h003;
        tick();
        expect_state("dual_fill", 4'd1, 4'd2, 12'h003, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        tick();
        expect_state("dual_revoke", 4'd0, 4'd0, 12'h000, 1'b1);
        tick();
        check_eq("dual_pulse_end", 32'(timeout), 32'd0);

        // All requesting, holders drop for one cycle: grants rotate in pairs and wrap.
        do_reset();
        req = 12'hFFF;
        for (int p = 0; p < 7; p++) begin
            logic [3:0]  ea;
            logic [3:0]  eb;
            logic [11:0] eg;
            ea = 4'((p % 6) * 2 + 1);
            eb = 4'((p % 6) * 2 + 2);
            eg = 12'(12'h003 << ((p % 6) * 2));
            tick();
            expect_state($sformatf("rotate%0d", p), ea, eb, eg, 1'b0);
            if (p < 6) begin
                req = 12'hFFF & ~eg;
                tick();
                check_eq($sformatf("rotate%0d_free", p), 32'(gnt), 32'd0);
                req = 12'hFFF;
            end
        end

        // Asynchronous reset while both slots are BUSY.
        #1;
        reset = 1'b1;
        #1;
        expect_state("async_reset", 4'd0, 4'd0, 12'h000, 1'b0);
        req = 12'h000;
        #1;
        reset = 1'b0;

        // Release of 4 on the same edge that 9 rises: A stays free, then takes 9.
        req = 12'h028;
        tick();
        expect_state("same_edge_fill", 4'd4, 4'd6, 12'h028, 1'b0);
        req = 12'h120;
        tick();
        expect_state("same_edge_release", 4'd0, 4'd6, 12'h020, 1'b0);
        tick();
        expect_state("same_edge_refill", 4'd9, 4'd6, 12'h120, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/dual_grant_arbiter.md
DUAL_GRANT_ARBITER -- requirements
Module: dual_grant_arbiter

Interface
REQ-001 Parameter: N, 12, number of requesters, indexed 1..N, with index 0 meaning "none".
REQ-002 Parameter: MAX_HOLD, 16, maximum consecutive cycles one grant may be held.
REQ-003 Port: clk  input  1  single system clock, rising-edge active.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  [N:1]  request lines, level-sensitive; a requester holds its line high while using the resource.
REQ-006 Port: gnt  output  [N:1]  registered grant vector; at most two bits set.
REQ-007 Port: id_a  output  [3:0]  registered index held in slot A; 0 when slot A is free.
REQ-008 Port: id_b  output  [3:0]  registered index held in slot B; 0 when slot B is free.
REQ-009 Port: timeout  output  1  one-cycle registered pulse when any slot is revoked by MAX_HOLD expiry.

Function
REQ-010 Each slot (A, B) SHALL run a two-state FSM: FREE -> BUSY on fill; BUSY -> FREE on release or revoke.
REQ-011 Release SHALL occur on the first rising edge where req[holder]=0; the slot SHALL be FREE in the following cycle and refillable no earlier than that cycle.
REQ-012 Each BUSY slot SHALL carry a hold counter, cleared on fill and incremented each BUSY cycle; when it reaches MAX_HOLD-1 with req[holder] still high, the slot SHALL go FREE and timeout SHALL pulse for 1 cycle.
REQ-013 A revoked requester SHALL be masked from selection until it deasserts req for at least one cycle.
REQ-014 Eligible set = req AND NOT(held by A or B) AND NOT(masked).
REQ-015 Selection SHALL be round-robin: scan the eligible set starting at index ptr and wrap N -> 1; the first hit is "first" and the next hit is "second".
REQ-016 If both slots are FREE, A SHALL take first and B SHALL take second (if any) in the same cycle; if only one slot is FREE, it SHALL take first.
REQ-017 ptr SHALL advance to (last index granted this cycle)+1, wrapping N+1 -> 1; it SHALL remain unchanged when no grant is made.
REQ-018 Latency: req rising at edge k with a slot FREE and no competitor -> gnt bit and id set after edge k+1, i.e. one-cycle registered latency.
REQ-019 Same-edge release and new request: the freed slot SHALL NOT be refilled on that edge; the holder SHALL NOT be re-granted on that edge.
REQ-020 Simultaneous expiry of both slots SHALL produce a single timeout pulse.
REQ-021 gnt SHALL equal the OR of onehot(id_a) and onehot(id_b) at all times; id_a SHALL never equal id_b when both are nonzero.

Reset
REQ-022 On reset: gnt=0, id_a=0, id_b=0, timeout=0, both slots FREE, counters=0, mask=0, ptr=1.
REQ-023 Reset asserted mid-grant SHALL clear all state immediately, without waiting for clk.
REQ-024 After reset deasserts, the first grant SHALL occur at the first rising edge with an eligible request.

Structure
REQ-025 Shared header SHALL hold N, MAX_HOLD default, the FSM state encodings FREE/BUSY, and the index width (4).
REQ-026 One sub-module, rr_dual_select, SHALL be combinational: inputs eligible[N:1] and ptr; outputs first and second 4-bit indices, with 0 meaning none.
REQ-027 All outputs SHALL be driven directly from registers.

Verification
REQ-028 Reset, then req=12'h001 -> id_a=1, gnt=12'h001 one cycle later; drop req -> id_a=0 one cycle after release.
REQ-029 Reset (ptr=1), req bits 3, 7, 12 set together -> id_a=3, id_b=7, ptr=8; release index 3 -> slot A takes 12 next cycle.
REQ-030 req[5] held for 20 cycles -> revoked after 16 BUSY cycles, timeout high for 1 cycle, and no re-grant until req[5] toggles low.
REQ-031 All 12 req high, holders releasing after one cycle each -> grants rotate 1,2 / 3,4 / ... / 11,12 / 1,2 with no starvation.
REQ-032 Reset asserted while both slots are BUSY -> gnt=0, id_a=id_b=0 before the next clk edge.
REQ-033 Same-edge release of index 4 while req[9] rises -> slot A stays FREE that cycle and grants 9 on the next edge.
